// File: rtl/core_pkg.sv
// core_pkg: shared LSU types, state encoding and access-size decode
package core_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT} lsu_state_e;
  typedef enum logic [1:0] {BYTE, HALF, WORD} mem_size_e;
  typedef enum logic [1:0] {
    EXC_NONE      = 2'b00,
    EXC_LOAD_MIS  = 2'b01,
    EXC_STORE_MIS = 2'b10,
    EXC_TIMEOUT   = 2'b11
  } exc_cause_e;
  function automatic mem_size_e size_of(input logic [2:0] f3);
    return f3[1:0] == 2'b00 ? BYTE : f3[1:0] == 2'b01 ? HALF : WORD;
  endfunction
endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: extracts the addressed lane of a read word and sign/zero extends it
module lsu_load_align
  import core_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] val
);
  logic [31:0] lane;
  mem_size_e   sz;
  logic        sx;
  assign sz = size_of(funct3);
  assign sx = ~funct3[2];
  // shift the addressed byte down to lane 0, then extend by access size
  always_comb begin
    lane = rdata >> {off, 3'b000};
    val  = sz == BYTE ? {{24{sx & lane[7]}}, lane[7:0]} :
           sz == HALF ? {{16{sx & lane[15]}}, lane[15:0]} : lane;
  end
endmodule

// File: rtl/lsu.sv
// lsu: load/store unit with one outstanding bus transaction and registered write-back
module lsu
  import core_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int TIMEOUT_CYC = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            exValid,
  output logic            exReady,
  input  logic            memRead,
  input  logic            memWrite,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] aluResult,
  input  logic [XLEN-1:0] storeData,
  input  logic [4:0]      rdIn,
  output logic            dmemReq,
  output logic            dmemWe,
  output logic [XLEN-1:0] dmemAddr,
  output logic [3:0]      dmemBe,
  output logic [XLEN-1:0] dmemWdata,
  input  logic            dmemGnt,
  input  logic            dmemRvalid,
  input  logic [XLEN-1:0] dmemRdata,
  output logic            wbValid,
  input  logic            wbReady,
  output logic [XLEN-1:0] wbData,
  output logic [4:0]      wbRd,
  output logic [1:0]      excCause
);
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYC) - 32'd1;
  lsu_state_e      state, state_n;
  mem_size_e       sz;
  exc_cause_e      res_c;
  logic            accept, mem_op, misal, go_bus, timed_out, ld, req_n, op_load;
  logic [2:0]      op_f3;
  logic [4:0]      op_rd, res_rd;
  logic [31:0]     cnt;
  logic [3:0]      be_n;
  logic [XLEN-1:0] op_addr, res_d, load_val, wd_n;
  assign exReady   = state == IDLE && (!wbValid || wbReady);
  assign accept    = exValid && exReady;
  assign mem_op    = memRead || memWrite;
  assign sz        = size_of(funct3);
  assign misal     = (sz == HALF && aluResult[0]) || (sz == WORD && aluResult[1:0] != 2'b00);
  assign go_bus    = accept && mem_op && !misal;
  assign timed_out = TIMEOUT_CYC != 0 && cnt == TO_LAST;
  assign be_n      = sz == BYTE ? 4'b0001 << aluResult[1:0] :
                     sz == HALF ? 4'b0011 << aluResult[1:0] : 4'b1111;
  assign wd_n      = sz == BYTE ? {4{storeData[7:0]}} :
                     sz == HALF ? {2{storeData[15:0]}} : storeData;
  lsu_load_align u_align (
    .rdata (dmemRdata),
    .off   (op_addr[1:0]),
    .funct3(op_f3),
    .val   (load_val)
  );
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  // next state, bus request and the value to load into the result register
  always_comb begin
    state_n = state;
    ld      = 1'b0;
    req_n   = dmemReq;
    res_d   = aluResult;
    res_rd  = rdIn;
    res_c   = EXC_NONE;
    case (state)
      IDLE: if (accept) begin
        state_n = go_bus ? REQ : IDLE;
        req_n   = go_bus;
        ld      = !mem_op || misal;
        res_rd  = mem_op ? 5'd0 : rdIn;
        res_c   = !mem_op ? EXC_NONE : memRead ? EXC_LOAD_MIS : EXC_STORE_MIS;
      end
      REQ: if (dmemGnt) begin
        state_n = op_load ? WAIT : IDLE;
        req_n   = 1'b0;
        ld      = !op_load;
        res_d   = op_addr;
        res_rd  = 5'd0;
      end else if (timed_out) begin
        state_n = IDLE;
        req_n   = 1'b0;
        ld      = 1'b1;
        res_d   = op_addr;
        res_rd  = 5'd0;
        res_c   = EXC_TIMEOUT;
      end
      WAIT: if (dmemRvalid) begin
        state_n = IDLE;
        ld      = 1'b1;
        res_d   = load_val;
        res_rd  = op_rd;
      end else if (timed_out) begin
        state_n = IDLE;
        ld      = 1'b1;
        res_d   = op_addr;
        res_rd  = 5'd0;
        res_c   = EXC_TIMEOUT;
      end
      default: state_n = IDLE;
    endcase
  end
  // wait counter restarts on every entry into REQ or WAIT
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else        cnt <= (state != IDLE && state_n == state) ? cnt + 32'd1 : '0;
  // bus outputs and operation context, captured at accept and held until done
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      dmemReq   <= 1'b0;
      dmemWe    <= 1'b0;
      dmemAddr  <= '0;
      dmemBe    <= '0;
      dmemWdata <= '0;
      op_load   <= 1'b0;
      op_f3     <= '0;
      op_rd     <= '0;
      op_addr   <= '0;
    end else begin
      dmemReq <= req_n;
      if (go_bus) begin
        dmemWe    <= memWrite;
        dmemAddr  <= {aluResult[XLEN-1:2], 2'b00};
        dmemBe    <= be_n;
        dmemWdata <= wd_n;
        op_load   <= memRead;
        op_f3     <= funct3;
        op_rd     <= rdIn;
        op_addr   <= aluResult;
      end
    end
  // write-back result register; a new load wins over a same-cycle drain
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wbValid  <= 1'b0;
      wbData   <= '0;
      wbRd     <= '0;
      excCause <= EXC_NONE;
    end else if (ld) begin
      wbValid  <= 1'b1;
      wbData   <= res_d;
      wbRd     <= res_rd;
      excCause <= res_c;
    end else if (wbValid && wbReady) wbValid <= 1'b0;
endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed and randomized checks of lsu against an arithmetic reference model
module tb_lsu;
  logic clk = 1'b0, rst_n = 1'b0;
  logic exValid = 0, memRead = 0, memWrite = 0, dmemGnt = 0, dmemRvalid = 0, wbReady = 1;
  logic [2:0] funct3 = 0;
  logic [31:0] aluResult = 0, storeData = 0, dmemRdata = 0;
  logic [4:0] rdIn = 0;
  logic exReady, dmemReq, dmemWe, wbValid;
  logic [31:0] dmemAddr, dmemWdata, wbData;
  logic [3:0] dmemBe;
  logic [4:0] wbRd;
  logic [1:0] excCause;
  logic exReady1, dmemReq1, dmemWe1, wbValid1;
  logic [31:0] dmemAddr1, dmemWdata1, wbData1;
  logic [3:0] dmemBe1;
  logic [4:0] wbRd1;
  logic [1:0] excCause1;
  int errors = 0, checks = 0;
  logic [31:0] last_wb, last_addr, last_wd;
  logic [3:0] last_be;
  logic [1:0] last_cause;
  always #5 clk = ~clk;
  lsu #(.XLEN(32), .TIMEOUT_CYC(0)) dut (
    .clk(clk), .rst_n(rst_n), .exValid(exValid), .exReady(exReady), .memRead(memRead),
    .memWrite(memWrite), .funct3(funct3), .aluResult(aluResult), .storeData(storeData),
    .rdIn(rdIn), .dmemReq(dmemReq), .dmemWe(dmemWe), .dmemAddr(dmemAddr), .dmemBe(dmemBe),
    .dmemWdata(dmemWdata), .dmemGnt(dmemGnt), .dmemRvalid(dmemRvalid), .dmemRdata(dmemRdata),
    .wbValid(wbValid), .wbReady(wbReady), .wbData(wbData), .wbRd(wbRd), .excCause(excCause)
  );
  lsu #(.XLEN(32), .TIMEOUT_CYC(4)) dut_to (
    .clk(clk), .rst_n(rst_n), .exValid(exValid), .exReady(exReady1), .memRead(memRead),
    .memWrite(memWrite), .funct3(funct3), .aluResult(aluResult), .storeData(storeData),
    .rdIn(rdIn), .dmemReq(dmemReq1), .dmemWe(dmemWe1), .dmemAddr(dmemAddr1), .dmemBe(dmemBe1),
    .dmemWdata(dmemWdata1), .dmemGnt(dmemGnt), .dmemRvalid(dmemRvalid), .dmemRdata(dmemRdata),
    .wbValid(wbValid1), .wbReady(wbReady), .wbData(wbData1), .wbRd(wbRd1), .excCause(excCause1)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [31:0] ref_load(input logic [31:0] rdata, addr, input logic [2:0] f3);
    logic [31:0] v;
    v = rdata >> (8 * (addr % 4));
    if (f3[1:0] == 2'd0) begin
      v = v % 256;
      if (!f3[2] && v >= 128) v = v - 256;
    end else if (f3[1:0] == 2'd1) begin
      v = v % 65536;
      if (!f3[2] && v >= 32768) v = v - 65536;
    end else v = rdata;
    return v;
  endfunction
  function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] addr);
    return f3[1:0] == 2'd0 ? 4'(1 << (addr % 4)) : f3[1:0] == 2'd1 ? 4'(3 << (addr % 4)) : 4'd15;
  endfunction
  function automatic logic [31:0] ref_wd(input logic [2:0] f3, input logic [31:0] sd);
    return f3[1:0] == 2'd0 ? (sd % 256) * 32'h01010101 :
           f3[1:0] == 2'd1 ? (sd % 65536) * 32'h00010001 : sd;
  endfunction
  function automatic logic ref_mis(input logic [2:0] f3, input logic [31:0] addr);
    return f3[1:0] == 2'd1 ? addr % 2 != 0 : f3[1:0] >= 2'd2 ? addr % 4 != 0 : 1'b0;
  endfunction
  task automatic do_op(input logic ld, st, input logic [2:0] f3, input logic [31:0] a, sd, rdat,
                       input logic [4:0] rd, input int gd, rvd);
    logic mem, mis;
    mem = ld | st;
    mis = mem && ref_mis(f3, a);
    memRead = ld; memWrite = st; funct3 = f3; aluResult = a; storeData = sd; rdIn = rd;
    exValid = 1;
    #1;
    chk("ex_ready", 32'(exReady), 32'd1);
    tick();
    exValid = 0; memRead = 0; memWrite = 0;
    if (!mem || mis) begin
      chk("no_req", 32'(dmemReq), 32'd0);
      chk("wb_valid_1cyc", 32'(wbValid), 32'd1);
      chk("wb_data_pass", wbData, a);
      chk("wb_rd_pass", 32'(wbRd), mis ? 32'd0 : 32'(rd));
      chk("cause_pass", 32'(excCause), !mis ? 32'd0 : ld ? 32'd1 : 32'd2);
    end else begin
      for (int i = 0; i <= gd; i++) begin
        chk("req_ctl", {26'd0, dmemReq, dmemWe, dmemBe}, {26'd0, 1'b1, st, ref_be(f3, a)});
        chk("req_addr", dmemAddr, a & ~32'h3);
        if (st) chk("req_wdata", dmemWdata, ref_wd(f3, sd));
        chk("req_no_wb", 32'(wbValid), 32'd0);
        last_addr = dmemAddr; last_be = dmemBe; last_wd = dmemWdata;
        dmemGnt = (i == gd);
        tick();
      end
      dmemGnt = 0;
      chk("req_dropped", 32'(dmemReq), 32'd0);
      if (st) begin
        chk("st_wb_valid", 32'(wbValid), 32'd1);
        chk("st_wb_rd", 32'(wbRd), 32'd0);
        chk("st_cause", 32'(excCause), 32'd0);
      end else begin
        chk("ld_wait_no_wb", 32'(wbValid), 32'd0);
        repeat (rvd) begin
          tick();
          chk("ld_wait_no_wb", 32'(wbValid), 32'd0);
        end
        dmemRvalid = 1; dmemRdata = rdat;
        tick();
        dmemRvalid = 0; dmemRdata = $urandom;
        chk("ld_wb_valid", 32'(wbValid), 32'd1);
        chk("ld_wb_data", wbData, ref_load(rdat, a, f3));
        chk("ld_wb_rd", 32'(wbRd), 32'(rd));
        chk("ld_cause", 32'(excCause), 32'd0);
      end
    end
    last_wb = wbData; last_cause = excCause;
    tick();
    chk("drained", 32'(wbValid), 32'd0);
  endtask
  initial begin
    logic [2:0] ld_f3 [5];
    ld_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    tick();
    tick();
    chk("rst_wb_valid", 32'(wbValid), 32'd0);
    chk("rst_req", {26'd0, dmemReq, dmemWe, dmemBe}, 32'd0);
    chk("rst_addr", dmemAddr, 32'd0);
    chk("rst_wdata", dmemWdata, 32'd0);
    chk("rst_wb", {25'd0, excCause, wbRd}, 32'd0);
    chk("rst_wb_data", wbData, 32'd0);
    rst_n = 1;
    tick();
    chk("rst_ready", 32'(exReady), 32'd1);
    do_op(1, 0, 3'b010, 32'h100, 32'd0, 32'hDEADBEEF, 5'd3, 0, 0);
    chk("lw_const", last_wb, 32'hDEADBEEF);
    do_op(1, 0, 3'b000, 32'h103, 32'd0, 32'h80FF0000, 5'd4, 0, 0);
    chk("lb_const", last_wb, 32'hFFFFFF80);
    do_op(1, 0, 3'b100, 32'h103, 32'd0, 32'h80FF0000, 5'd4, 1, 0);
    chk("lbu_const", last_wb, 32'h00000080);
    do_op(1, 0, 3'b101, 32'h102, 32'd0, 32'h80FF0000, 5'd5, 0, 1);
    chk("lhu_const", last_wb, 32'h000080FF);
    do_op(0, 1, 3'b000, 32'h201, 32'h123456AB, 32'd0, 5'd6, 0, 0);
    chk("sb_be_const", 32'(last_be), 32'h2);
    chk("sb_wd_const", last_wd, 32'hABABABAB);
    chk("sb_addr_const", last_addr, 32'h200);
    do_op(0, 1, 3'b001, 32'h301, 32'h5555AAAA, 32'd0, 5'd7, 0, 0);
    chk("sh_mis_data", last_wb, 32'h301);
    chk("sh_mis_cause", 32'(last_cause), 32'd2);
    do_op(1, 0, 3'b010, 32'h402, 32'd0, 32'd0, 5'd8, 0, 0);
    do_op(1, 0, 3'b010, 32'h600, 32'd0, 32'h0BADF00D, 5'd9, 5, 0);
    do_op(0, 0, 3'b000, 32'hCAFE0001, 32'd0, 32'd0, 5'd10, 0, 0);
    for (int n = 0; n < 40; n++) begin
      int k;
      logic [2:0] f;
      k = $urandom_range(2, 0);
      f = k == 1 ? ld_f3[$urandom_range(4, 0)] : 3'($urandom_range(2, 0));
      do_op(k == 1, k == 2, f, $urandom, $urandom, $urandom, 5'($urandom_range(31, 1)),
            $urandom_range(3, 0), $urandom_range(2, 0));
    end
    memRead = 0; memWrite = 0; rdIn = 5'd11; aluResult = 32'h11111111; exValid = 1;
    tick();
    rdIn = 5'd12; aluResult = 32'h22222222;
    #1;
    chk("b2b_ready", 32'(exReady), 32'd1);
    tick();
    exValid = 0;
    chk("b2b_valid", 32'(wbValid), 32'd1);
    chk("b2b_data", wbData, 32'h22222222);
    chk("b2b_rd", 32'(wbRd), 32'd12);
    tick();
    chk("b2b_drained", 32'(wbValid), 32'd0);
    wbReady = 0; rdIn = 5'd13; aluResult = 32'h33333333; exValid = 1;
    tick();
    aluResult = 32'h44444444; rdIn = 5'd14;
    #1;
    chk("bp_valid", 32'(wbValid), 32'd1);
    chk("bp_not_ready", 32'(exReady), 32'd0);
    tick();
    exValid = 0;
    chk("bp_hold_data", wbData, 32'h33333333);
    chk("bp_hold_rd", 32'(wbRd), 32'd13);
    wbReady = 1;
    #1;
    chk("bp_ready_again", 32'(exReady), 32'd1);
    tick();
    chk("bp_drained", 32'(wbValid), 32'd0);
    dmemRvalid = 1; dmemRdata = 32'h12345678;
    tick();
    dmemRvalid = 0;
    chk("idle_rvalid_ignored", 32'(wbValid), 32'd0);
    memRead = 1; funct3 = 3'b010; aluResult = 32'h700; rdIn = 5'd15; exValid = 1;
    tick();
    exValid = 0; memRead = 0; dmemGnt = 1;
    tick();
    dmemGnt = 0;
    rst_n = 0;
    #1;
    chk("rst_wait_req", 32'(dmemReq), 32'd0);
    chk("rst_wait_wb", 32'(wbValid), 32'd0);
    chk("rst_wait_ready", 32'(exReady), 32'd1);
    #1;
    rst_n = 1;
    dmemRvalid = 1; dmemRdata = 32'hFEEDFACE;
    tick();
    dmemRvalid = 0;
    chk("rst_late_rvalid", 32'(wbValid), 32'd0);
    tick();
    chk("rst_late_rvalid2", 32'(wbValid), 32'd0);
    memRead = 1; funct3 = 3'b010; aluResult = 32'h500; rdIn = 5'd9; exValid = 1;
    tick();
    exValid = 0; memRead = 0;
    chk("to_req", 32'(dmemReq1), 32'd1);
    dmemGnt = 1;
    tick();
    dmemGnt = 0;
    chk("to_wait_0", 32'(wbValid1), 32'd0);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk("to_wait_n", 32'(wbValid1), 32'd0);
    end
    tick();
    chk("to_valid", 32'(wbValid1), 32'd1);
    chk("to_cause", 32'(excCause1), 32'd3);
    chk("to_data", wbData1, 32'h500);
    chk("to_rd", 32'(wbRd1), 32'd0);
    chk("to_req_off", 32'(dmemReq1), 32'd0);
    chk("no_to_dut0", 32'(wbValid), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
